// File: rtl/fifth_data_port_pkg.sv
// Shared constants for the fifth data-memory port: I/O page addresses, STATUS bits, UART states.
// No logic or latency of its own.
// No flow control; constants and one decode helper only.
package fifth_pkg;

    localparam logic [15:0] IO_BASE       = 16'hF000;
    localparam logic [15:0] ADDR_TXDATA   = 16'hF000;
    localparam logic [15:0] ADDR_STATUS   = 16'hF001;
    localparam logic [15:0] ADDR_BAUDDIV  = 16'hF002;
    localparam logic [15:0] ADDR_TIMER_LO = 16'hF003;
    localparam logic [15:0] ADDR_TIMER_HI = 16'hF004;

    localparam int STS_BUSY    = 0;
    localparam int STS_FULL    = 1;
    localparam int STS_EMPTY   = 2;
    localparam int STS_OVF     = 3;
    localparam int STS_CNT_LSB = 8;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // The whole top 4K page belongs to I/O; everything below is RAM.
    function automatic logic is_io(input logic [15:0] addr);
        return addr[15:12] == IO_BASE[15:12];
    endfunction

endpackage

// File: rtl/fifth_data_port_if.sv
// CPU data-memory bus between the fifth core (master) and its data port (slave).
// Read data returns one cycle after the address.
// No backpressure: the responder accepts every access.
interface fifth_data_port_if;
    logic [15:0] mem_address;
    logic        mem_write_enable;
    logic [15:0] mem_data_output;
    logic [15:0] mem_data_input;

    modport master (output mem_address, output mem_write_enable, output mem_data_output,
                    input  mem_data_input);
    modport slave  (input  mem_address, input  mem_write_enable, input  mem_data_output,
                    output mem_data_input);
endinterface

// File: rtl/fifth_fifo.sv
// Generic synchronous FIFO with occupancy count and first-word fall-through read.
// Push visible at the output one cycle later.
// Push while full and pop while empty are ignored; full/empty use the pre-edge count.
module fifth_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_vld,
    output logic [DW-1:0] pop_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fifth_uart_tx.sv
// FIFO-buffered 8N1 transmitter with programmable baud divisor and sticky overflow flag.
// uart_tx is registered from the FSM state, so it trails the state by one cycle.
// Pushes into a full FIFO are dropped and raise overflow; nothing stalls the writer.
module fifth_uart_tx
    import fifth_pkg::*;
#(
    parameter int          FIFO_AW        = 3,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd434
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_vld,
    input  logic [7:0]         push_dat,
    input  logic               baud_wr,
    input  logic [15:0]        baud_dat,
    input  logic               ovf_clr,
    output logic               busy,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic [FIFO_AW:0]   count,
    output logic [15:0]        baud_div,
    output logic               uart_tx
);
    uart_state_t state, state_nxt;
    logic [15:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [7:0]  pop_dat;
    logic        pop;
    logic        line;
    logic        bit_end;
    logic [15:0] reload;

    fifth_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .pop_dat  (pop_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign busy    = (state != UART_IDLE);
    assign bit_end = (bit_cnt == 16'd0);
    assign reload  = baud_div - 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_div <= BAUD_DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (baud_wr) baud_div <= (baud_dat == 16'd0) ? 16'd1 : baud_dat;
            // A drop on the same edge as a clear must not be lost.
            if (push_vld && full) overflow <= 1'b1;
            else if (ovf_clr)     overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= UART_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            uart_tx <= line;
        end
    end

    // The divisor is re-read only on reload, so a BAUDDIV write lands at the next bit boundary.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_end ? reload : bit_cnt - 16'd1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        line        = 1'b1;
        case (state)
            UART_IDLE: begin
                bit_cnt_nxt = bit_cnt;
                if (!empty) begin
                    pop         = 1'b1;
                    shift_nxt   = pop_dat;
                    bit_cnt_nxt = reload;
                    state_nxt   = UART_START;
                end
            end
            UART_START: begin
                line = 1'b0;
                if (bit_end) begin
                    bit_idx_nxt = 3'd0;
                    state_nxt   = UART_DATA;
                end
            end
            UART_DATA: begin
                line = shift[0];
                if (bit_end) begin
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = UART_STOP;
                end
            end
            UART_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = pop_dat;
                        state_nxt = UART_START;
                    end else begin
                        state_nxt = UART_IDLE;
                    end
                end
            end
            default: state_nxt = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/fifth_data_port.sv
// Data-memory responder for the fifth CPU: RAM below 0xF000, UART/timer I/O page above.
// Read data one cycle after the address; optional timer built when FIFTH_DATA_PORT_TIMER_EN is defined.
// Never stalls the CPU; UART bytes pushed into a full FIFO are dropped and flagged.
module fifth_data_port
    import fifth_pkg::*;
#(
    parameter int          RAM_AW         = 10,
    parameter int          FIFO_AW        = 3,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd434
) (
    input  logic               clk,
    input  logic               reset,
    fifth_data_port_if.slave   bus,
    output logic               uart_tx
);
    logic              io_sel;
    logic              ram_we;
    logic              push;
    logic              baud_wr;
    logic              ovf_clr;
    logic              busy, full, empty, overflow;
    logic [FIFO_AW:0]  count;
    logic [15:0]       baud_div;
    logic [15:0]       status_word;
    logic [15:0]       io_rdata;
    logic [15:0]       io_q;
    logic [15:0]       ram_q;
    logic              rd_ram;
    logic [15:0]       ram [1 << RAM_AW];

    assign io_sel  = is_io(bus.mem_address);
    assign ram_we  = bus.mem_write_enable && !io_sel;
    assign push    = bus.mem_write_enable && (bus.mem_address == ADDR_TXDATA);
    assign baud_wr = bus.mem_write_enable && (bus.mem_address == ADDR_BAUDDIV);
    assign ovf_clr = bus.mem_write_enable && (bus.mem_address == ADDR_STATUS)
                     && bus.mem_data_output[STS_OVF];

    fifth_uart_tx #(.FIFO_AW(FIFO_AW), .BAUD_DIV_RESET(BAUD_DIV_RESET)) u_uart (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push),
        .push_dat (bus.mem_data_output[7:0]),
        .baud_wr  (baud_wr),
        .baud_dat (bus.mem_data_output),
        .ovf_clr  (ovf_clr),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .count    (count),
        .baud_div (baud_div),
        .uart_tx  (uart_tx)
    );

    // Read-before-write: a same-edge read of the written word returns the old value.
    always_ff @(posedge clk) begin
        if (ram_we) ram[bus.mem_address[RAM_AW-1:0]] <= bus.mem_data_output;
        ram_q <= ram[bus.mem_address[RAM_AW-1:0]];
    end

`ifdef FIFTH_DATA_PORT_TIMER_EN
    logic [31:0] timer;
    logic [15:0] timer_shadow;

    // Reading the low half freezes the high half so the pair reads as one value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer        <= '0;
            timer_shadow <= '0;
        end else begin
            timer <= timer + 32'd1;
            if (bus.mem_address == ADDR_TIMER_LO) timer_shadow <= timer[31:16];
        end
    end
`endif

    always_comb begin
        status_word = '0;
        status_word[STS_BUSY]  = busy;
        status_word[STS_FULL]  = full;
        status_word[STS_EMPTY] = empty;
        status_word[STS_OVF]   = overflow;
        status_word[STS_CNT_LSB +: FIFO_AW+1] = count;
    end

    always_comb begin
        io_rdata = '0;
        case (bus.mem_address)
            ADDR_STATUS:   io_rdata = status_word;
            ADDR_BAUDDIV:  io_rdata = baud_div;
`ifdef FIFTH_DATA_PORT_TIMER_EN
            ADDR_TIMER_LO: io_rdata = timer[15:0];
            ADDR_TIMER_HI: io_rdata = timer_shadow;
`endif
            default:       io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ram <= 1'b0;
            io_q   <= '0;
        end else begin
            rd_ram <= !io_sel;
            io_q   <= io_rdata;
        end
    end

    assign bus.mem_data_input = rd_ram ? ram_q : io_q;

endmodule

// File: tb/tb_fifth_data_port.sv
// Scoreboard bench for fifth_data_port: read expectations and UART frames queued at stimulus time.
module tb_fifth_data_port;
    import fifth_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;

    fifth_data_port_if bus();

    fifth_data_port #(.RAM_AW(10), .FIFO_AW(3), .BAUD_DIV_RESET(16'd434)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bench model of the free-running timer.
    logic [31:0] cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    // Read scoreboard
    int          rd_due[$];
    logic [15:0] rd_exp[$];
    string       rd_tag[$];

    always @(negedge clk) begin
        while (rd_due.size() > 0 && rd_due[0] == int'(cyc)) begin
            void'(rd_due.pop_front());
            check(rd_tag.pop_front(), bus.mem_data_input, rd_exp.pop_front());
        end
    end

    task automatic op(input logic [15:0] a, input logic w, input logic [15:0] d,
                      input logic chk, input logic [15:0] e, input string tag);
        @(negedge clk);
        bus.mem_address      = a;
        bus.mem_write_enable = w;
        bus.mem_data_output  = d;
        if (chk) begin
            rd_due.push_back(int'(cyc) + 1);
            rd_exp.push_back(e);
            rd_tag.push_back(tag);
        end
        @(posedge clk);
        #1;
        bus.mem_write_enable = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        op(a, 1'b1, d, 1'b0, 16'h0, "");
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string tag);
        op(a, 1'b0, 16'h0, 1'b1, e, tag);
    endtask

    // UART frame scoreboard (monitor assumes BAUDDIV=4)
    logic [7:0] fq[$];
    int   frames_seen = 0;
    int   gap = 0;
    int   last_gap = -1;
    int   nsamp = 0;
    logic mon_en = 1'b1;
    logic [39:0] fr;

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [9:0]  lv;
        logic [39:0] r;
        lv = {1'b1, b, 1'b0};
        for (int k = 0; k < 40; k++) r[k] = lv[k/4];
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            nsamp = 0;
            gap   = 0;
        end else if (nsamp == 0 && uart_tx === 1'b1) begin
            gap++;
        end else begin
            fr[nsamp] = uart_tx;
            nsamp++;
            if (nsamp == 40) begin
                if (fq.size() == 0) check("frame_unexpected", fr, 40'h0);
                else                check("frame", fr, frame_bits(fq.pop_front()));
                frames_seen++;
                last_gap = gap;
                gap   = 0;
                nsamp = 0;
            end
        end
    end

    task automatic tx_push(input logic [7:0] b, input logic sent);
        if (sent) fq.push_back(b);
        wr(ADDR_TXDATA, {8'h00, b});
    endtask

    task automatic wait_frames(input int target, input int budget);
        int i;
        i = 0;
        while (frames_seen < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("frames_done", frames_seen, target);
    endtask

`ifdef FIFTH_DATA_PORT_TIMER_EN
    task automatic timer_sample(input string tag);
        logic [31:0] t;
        @(negedge clk);
        t = cyc;
        bus.mem_address = ADDR_TIMER_LO;
        rd_due.push_back(int'(cyc) + 1);
        rd_exp.push_back(t[15:0]);
        rd_tag.push_back({tag, "_lo"});
        @(posedge clk);
        #1;
        rd(ADDR_TIMER_HI, t[31:16], {tag, "_hi"});
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mem_address      = 16'h0;
        bus.mem_write_enable = 1'b0;
        bus.mem_data_output  = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", bus.mem_data_input, 16'h0);
        check("rst_tx", uart_tx, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        rd(ADDR_STATUS, 16'h0004, "rst_status");
        rd(ADDR_BAUDDIV, 16'd434, "rst_baud");

        // RAM, aliasing, read-before-write, unmapped I/O
        wr(16'h0005, 16'h1234);
        rd(16'h0005, 16'h1234, "ram_rd");
        rd(16'h0405, 16'h1234, "ram_alias");
        wr(16'h0010, 16'h1111);
        op(16'h0010, 1'b1, 16'h2222, 1'b1, 16'h1111, "ram_rbw_old");
        rd(16'h0010, 16'h2222, "ram_rbw_new");
        wr(16'hEFFF, 16'h5A5A);
        rd(16'h03FF, 16'h5A5A, "ram_top_alias");
        wr(16'h000F, 16'h7777);
        wr(16'hF00F, 16'hDEAD);
        rd(16'h000F, 16'h7777, "io_wr_no_ram");
        rd(16'hF00F, 16'h0000, "io_unmapped");
        rd(ADDR_TXDATA, 16'h0000, "txdata_rd");

        wr(ADDR_BAUDDIV, 16'h0000);
        rd(ADDR_BAUDDIV, 16'h0001, "baud_zero");
        wr(ADDR_BAUDDIV, 16'h0004);
        rd(ADDR_BAUDDIV, 16'h0004, "baud_four");

`ifdef FIFTH_DATA_PORT_TIMER_EN
        timer_sample("timer_a");
        repeat (37) @(posedge clk);
        timer_sample("timer_b");
`else
        rd(ADDR_TIMER_LO, 16'h0000, "timer_lo_off");
        rd(ADDR_TIMER_HI, 16'h0000, "timer_hi_off");
`endif

        // Single frame and start-bit latency
        tx_push(8'hA5, 1'b1);
        @(posedge clk); #1;
        check("tx_edge1_high", uart_tx, 1'b1);
        @(posedge clk); #1;
        check("tx_edge2_low", uart_tx, 1'b0);
        wait_frames(1, 100);

        // Two pushes: status while frame 1 runs, then back-to-back frames
        tx_push(8'h3C, 1'b1);
        tx_push(8'hC3, 1'b1);
        repeat (3) @(posedge clk);
        rd(ADDR_STATUS, 16'h0101, "sts_busy_cnt1");
        wait_frames(3, 200);
        check("pair_no_gap", last_gap, 0);

        // Overflow while busy: ninth push is dropped
        tx_push(8'h11, 1'b1);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 9; i++) tx_push(8'h20 + 8'(i), i < 8);
        rd(ADDR_STATUS, 16'h080B, "sts_full_ovf");
        wr(ADDR_STATUS, 16'h0008);
        rd(ADDR_STATUS, 16'h0803, "sts_ovf_clr");
        wait_frames(12, 9*40 + 100);
        check("burst_no_gap", last_gap, 0);
        repeat (100) @(posedge clk);
        check("frames_total", frames_seen, 12);
        check("frame_q_empty", fq.size(), 0);
        rd(ADDR_STATUS, 16'h0004, "sts_idle");

        // Reset in the middle of a data bit
        mon_en = 1'b0;
        wr(ADDR_TXDATA, 16'h0000);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("tx_low_in_data", uart_tx, 1'b0);
        reset = 1'b1;
        #1;
        check("tx_async_reset", uart_tx, 1'b1);
        check("rdata_async_reset", bus.mem_data_input, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(ADDR_STATUS, 16'h0004, "rst2_status");
        rd(ADDR_BAUDDIV, 16'd434, "rst2_baud");
        repeat (2) @(negedge clk);
        check("rd_q_empty", rd_due.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifth_data_port.md
# fifth_data_port

Responder for the fifth CPU's data-memory port: serves `mem_address` / `mem_write_enable` / `mem_data_output` and returns `mem_data_input`. Decodes the 16-bit word address into on-chip RAM and a small I/O page. The I/O page holds a FIFO-buffered 8N1 UART transmitter and, optionally, a 32-bit cycle timer. It sits beside the CPU at top level and gives fifth programs working storage and a console output.

## Interface
- `RAM_AW`, 10: RAM address width; RAM holds 2^RAM_AW 16-bit words.
- `FIFO_AW`, 3: TX FIFO depth is 2^FIFO_AW bytes.
- `BAUD_DIV_RESET`, 16'd434: reset value of the baud divisor, in clk cycles per bit.
- `clk` in 1: sole clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high.
- `mem_address` in 16: CPU word address, sampled every cycle.
- `mem_write_enable` in 1: write strobe, qualified with `mem_address` in the same cycle.
- `mem_data_output` in 16: CPU write data.
- `mem_data_input` out 16: read data for the address sampled at the previous edge.
- `uart_tx` out 1: serial line, registered, idles high.

## Operation
- Address map:
  - 0x0000–0xEFFF: RAM, indexed by `mem_address[RAM_AW-1:0]` (aliases).
  - 0xF000 TXDATA: write pushes `wdata[7:0]`; reads 0.
  - 0xF001 STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7+FIFO_AW+1:8] count.
  - 0xF002 BAUDDIV: R/W, 16 bits.
  - 0xF003 TIMER_LO, 0xF004 TIMER_HI.
  - All other 0xFxxx: reads 0, writes ignored.
- RAM: synchronous write when `mem_write_enable`; synchronous read every cycle. Write and read of the same address on the same edge returns the old data.
- STATUS write with `wdata[3]=1` clears overflow; other bits are read-only.
- BAUDDIV write of 0 is stored as 1.
- FIFO push when full: byte dropped, overflow set. Full/empty are evaluated on the pre-edge count, so a push while full is dropped even if a pop happens on the same edge.
- UART FSM states IDLE → START → DATA(8 bits, LSB first) → STOP.
  - Each state/bit lasts BAUDDIV cycles.
  - IDLE with FIFO non-empty: pop into shift register, enter START, `uart_tx`←0.
  - End of STOP with FIFO non-empty: go straight to START (pop); else IDLE.
  - A BAUDDIV change takes effect at the next bit boundary.
- Arithmetic: counters wrap modulo their width; the FIFO count is FIFO_AW+1 bits.

## Timing
- Reset values: `mem_data_input`=0, `uart_tx`=1, FSM IDLE, FIFO empty, overflow 0, BAUDDIV=BAUD_DIV_RESET, timer 0.
- Reset mid-frame: `uart_tx` goes high asynchronously and the pending FIFO contents are lost.
- Read latency is 1 cycle. `mem_data_input` holds until the next edge.
- STATUS/TIMER reads reflect state before that edge's updates, so a push on the same cycle is not visible.
- Push into an empty FIFO while IDLE: pop on the next edge. `uart_tx` falls 2 edges after the write edge.
- Frame length: 10×BAUDDIV cycles. Back-to-back frames have no idle gap.

## Configuration
- `FIFTH_DATA_PORT_TIMER_EN` defined:
  - 32-bit counter increments every cycle from reset.
  - Reading TIMER_LO returns bits[15:0] and latches bits[31:16] into a shadow register.
  - Reading TIMER_HI returns the shadow.
- Undefined: no counter or shadow is built; 0xF003/0xF004 read 0.

## Structure
- `fifth_pkg` holds:
  - address constants (TXDATA/STATUS/BAUDDIV/TIMER_LO/TIMER_HI, IO page base 0xF000);
  - STATUS bit indices;
  - UART state encodings (IDLE=0, START=1, DATA=2, STOP=3).
- Sub-module `fifth_uart_tx` contains the FIFO, the baud counter, the FSM and the shift register.
- Top-level `fifth_data_port` contains the decode, the RAM, the read mux and the timer.

## Test plan
- Write 0x1234 to 0x0005, read 0x0005 next cycle → `mem_data_input`=0x1234 one cycle later. Read 0x0405 with RAM_AW=10 → 0x1234 (alias).
- BAUDDIV=4, push 0xA5 → `uart_tx` pattern 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. Falls 2 edges after the write.
- Push 9 bytes back-to-back with FIFO_AW=3 and the FSM busy → STATUS shows full=1, overflow=1. Exactly 9 frames are sent, 8 of them from the FIFO. Writing STATUS 0x0008 clears overflow.
- Two pushes, then read STATUS while frame 1 is active → busy=1, count=1. Frames run with no idle-high gap between STOP and START.
- Assert `reset` mid-DATA → `uart_tx`=1 the same cycle. Then STATUS reads 0x0004 and BAUDDIV reads 434.
- With the timer macro, read TIMER_LO then TIMER_HI → a consistent 32-bit value that rises by the elapsed cycles across two samples. Without the macro → both read 0.
